regfile_sb: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It sits in the decode/writeback boundary of the RISC-V core. Decode reads operands and marks destination registers as pending at issue. Writeback ports commit results and clear the pending state. Architectural register x0 is hard-wired to zero, and a parameter mask selects which registers clear on reset.

---
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with pending-write scoreboard; define REGFILE_BYPASS_EN for write-to-read forwarding
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int READ_PORTS = 2,
  parameter int WRITE_PORTS = 2,
  parameter logic [REG_COUNT-1:0] RESET_MASK = 'h073fc00f,
  localparam int AW = $clog2(REG_COUNT),
  localparam int CW = $clog2(REG_COUNT + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [READ_PORTS*AW-1:0]          rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_busy,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*AW-1:0]         wr_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                              issue_en,
  input  logic [AW-1:0]                     issue_rd,
  input  logic                              flush,
  output logic [CW-1:0]                     busy_cnt
);
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // register writes; later ports overwrite earlier ones so the highest index wins, x0 stays zero
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < WRITE_PORTS; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    regs_d[0] = '0;
  end
  // scoreboard: write clears, then issue sets (newer producer), then flush clears everything
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WRITE_PORTS; w++)
      if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
    if (issue_en) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < REG_COUNT; i++) cnt_d = cnt_d + CW'(busy_d[i]);
  end
  // state update; reset clears only masked registers and leaves the rest untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q <= '0;
      for (int i = 1; i < REG_COUNT; i++)
        if (RESET_MASK[i]) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
    end
  end
  assign busy_cnt = cnt_q;
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic b;
    assign a = rd_addr[p*AW +: AW];
    // read mux over registered state, optionally overridden by a same-cycle writeback
    always_comb begin
      d = a == '0 ? '0 : regs_q[a];
      b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < WRITE_PORTS; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] == a && a != '0) begin
          d = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          b = issue_en && issue_rd == a;
        end
`endif
    end
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
    assign rd_busy[p] = b;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb storage, reset mask, scoreboard and forwarding
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic issue_en;
  logic [4:0] issue_rd;
  logic flush;
  logic [5:0] busy_cnt;
  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_rd(issue_rd), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    wr_en = '0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*5 +: 5] = a;
    wr_data[w*32 +: 32] = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en = 1'b1;
    issue_rd = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    issue_rd = '0;
    rd_addr = '0;
    step();
    idle();
    rd(0, 1);
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    chk("reset_busy", 64'(rd_busy), 64'd0);
    chk("reset_x1", 64'(rd_data[63:32]), 64'd0);

    wr(0, 1, 32'hAAAA_AAAA);
    wr(1, 5, 32'h5555_5555);
    step();
    idle();
    rd(1, 5);
    chk("preload_x1", 64'(rd_data[31:0]), 64'hAAAA_AAAA);
    chk("preload_x5", 64'(rd_data[63:32]), 64'h5555_5555);
    issue(6);
    step();
    idle();
    chk("preload_cnt", 64'(busy_cnt), 64'd1);
    rst = 1'b1;
    step();
    idle();
    rd(1, 5);
    chk("mask_x1", 64'(rd_data[31:0]), 64'd0);
    chk("mask_x5", 64'(rd_data[63:32]), 64'h5555_5555);
    chk("mask_cnt", 64'(busy_cnt), 64'd0);

    wr(0, 0, 32'hDEAD_BEEF);
    issue(0);
    step();
    idle();
    rd(0, 0);
    chk("x0_data", rd_data, 64'd0);
    chk("x0_busy", 64'(rd_busy), 64'd0);
    chk("x0_cnt", 64'(busy_cnt), 64'd0);

    wr(0, 7, 32'h1111);
    wr(1, 7, 32'h2222);
    step();
    idle();
    rd(7, 0);
    chk("collide_x7", 64'(rd_data[31:0]), 64'h2222);

    issue(3);
    step();
    idle();
    rd(3, 4);
    chk("iss3_cnt", 64'(busy_cnt), 64'd1);
    chk("iss3_busy", 64'(rd_busy), 64'b01);
    issue(4);
    step();
    idle();
    rd(3, 4);
    chk("iss4_cnt", 64'(busy_cnt), 64'd2);
    chk("iss4_busy", 64'(rd_busy), 64'b11);
    issue(3);
    wr(0, 3, 32'h33);
    step();
    idle();
    rd(3, 4);
    chk("reiss_cnt", 64'(busy_cnt), 64'd2);
    chk("reiss_busy", 64'(rd_busy), 64'b11);
    chk("reiss_data", 64'(rd_data[31:0]), 64'h33);
    wr(1, 4, 32'h44);
    step();
    idle();
    rd(3, 4);
    chk("wr4_cnt", 64'(busy_cnt), 64'd1);
    chk("wr4_busy", 64'(rd_busy), 64'b01);
    flush = 1'b1;
    issue(8);
    wr(0, 8, 32'h88);
    step();
    idle();
    rd(8, 3);
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    chk("flush_busy", 64'(rd_busy), 64'b00);
    chk("flush_data", 64'(rd_data[31:0]), 64'h88);

    wr(0, 9, 32'h1);
    issue(9);
    step();
    idle();
    rd(9, 0);
    chk("pre_byp_busy", 64'(rd_busy), 64'b01);
    wr(1, 9, 32'h1234);
    rd(9, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 64'(rd_data[31:0]), 64'h1234);
    chk("byp_busy", 64'(rd_busy), 64'b00);
`else
    chk("nobyp_data", 64'(rd_data[31:0]), 64'h1);
    chk("nobyp_busy", 64'(rd_busy), 64'b01);
`endif
    step();
    idle();
    rd(9, 0);
    chk("post_byp_data", 64'(rd_data[31:0]), 64'h1234);
    chk("post_byp_busy", 64'(rd_busy), 64'b00);

    wr(0, 10, 32'hA0);
    wr(1, 14, 32'hE);
    issue(12);
    step();
    idle();
    chk("mid_pre_cnt", 64'(busy_cnt), 64'd1);
    rst = 1'b1;
    wr(0, 10, 32'hBB);
    issue(11);
    flush = 1'b0;
    step();
    idle();
    rd(10, 14);
    chk("mid_x10", 64'(rd_data[31:0]), 64'hA0);
    chk("mid_x14", 64'(rd_data[63:32]), 64'd0);
    rd(11, 12);
    chk("mid_busy", 64'(rd_busy), 64'b00);
    chk("mid_cnt", 64'(busy_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
